// File: rtl/iob_wb_req_hold_pkg.sv
// Shared definitions for the IOb-to-Wishbone request hold stage: FSM encodings
// and the default watchdog length.
package iob_wb_req_hold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/iob_reg.sv
// Generic enabled register with asynchronous active-low reset to a fixed value.
module iob_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/iob_wb_timeout_cnt.sv
// Clearable, enabled, saturating counter; tc is high while the count sits at N-1.
module iob_wb_timeout_cnt #(
    parameter int N = 256
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign tc = (cnt_reg == CW'(N - 1));

    // Clear wins over enable; once at the terminal value the count stays put.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en && !tc) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    iob_reg #(.W(CW)) u_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (1'b1),
        .d      (cnt_next),
        .q      (cnt_reg)
    );

endmodule

// File: rtl/iob_wb_req_hold.sv
// Turns a 1-cycle upstream Wishbone strobe into a held downstream cycle and returns a
// 1-cycle ack/err. Watchdog built only when IOB_WB_REQ_HOLD_TIMEOUT_EN is defined.
module iob_wb_req_hold
    import iob_wb_req_hold_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic [ADDR_W-1:0]   s_adr_i,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic [DATA_W/8-1:0] s_sel_i,
    input  logic                s_we_i,
    input  logic                s_cyc_i,
    input  logic                s_stb_i,
    output logic [DATA_W-1:0]   s_dat_o,
    output logic                s_ack_o,
    output logic                s_err_o,
    output logic [ADDR_W-1:0]   m_adr_o,
    output logic [DATA_W-1:0]   m_dat_o,
    output logic [DATA_W/8-1:0] m_sel_o,
    output logic                m_we_o,
    output logic                m_cyc_o,
    output logic                m_stb_o,
    input  logic [DATA_W-1:0]   m_dat_i,
    input  logic                m_ack_i,
    input  logic                m_err_i,
    input  logic                clr_i,
    output logic                timeout_o,
    output logic                drop_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int REQ_W = ADDR_W + DATA_W + SEL_W + 1;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("iob_wb_req_hold: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0] state_q;
    state_t     state_reg;
    state_t     state_next;
    logic       req;
    logic       capture;
    logic       done_ack;
    logic       done_err;
    logic       done_to;
    logic       tc;
    logic       cyc_next;
    logic       drop_next;

    assign state_reg = state_t'(state_q);
    assign req       = s_cyc_i & s_stb_i;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        done_ack   = 1'b0;
        done_err   = 1'b0;
        done_to    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // err beats ack beats timeout; an ack on the terminal count is a plain ack
                if (m_err_i) begin
                    done_err   = 1'b1;
                    state_next = RESP;
                end else if (m_ack_i) begin
                    done_ack   = 1'b1;
                    state_next = RESP;
                end else if (tc) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cyc_next  = (state_next == BUSY);
    assign drop_next = (req && (state_reg != IDLE)) | (drop_o & ~clr_i);

    iob_reg #(.W(2), .RST_VAL(2'(IDLE))) u_state (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (2'(state_next)), .q (state_q)
    );

    iob_reg #(.W(REQ_W)) u_m_req (
        .clk    (clk_i),
        .arst_n (arst_n_i),
        .en     (capture),
        .d      ({s_adr_i, s_dat_i, s_sel_i, s_we_i}),
        .q      ({m_adr_o, m_dat_o, m_sel_o, m_we_o})
    );

    iob_reg #(.W(1)) u_m_cyc (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (cyc_next), .q (m_cyc_o)
    );
    assign m_stb_o = m_cyc_o;

    iob_reg #(.W(1)) u_s_ack (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (done_ack), .q (s_ack_o)
    );

    iob_reg #(.W(1)) u_s_err (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (done_err | done_to), .q (s_err_o)
    );

    // Read data only moves on a slave response, never on a timeout.
    iob_reg #(.W(DATA_W)) u_s_dat (
        .clk (clk_i), .arst_n (arst_n_i), .en (done_ack | done_err), .d (m_dat_i), .q (s_dat_o)
    );

    iob_reg #(.W(1)) u_drop (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (drop_next), .q (drop_o)
    );

`ifdef IOB_WB_REQ_HOLD_TIMEOUT_EN
    iob_wb_timeout_cnt #(.N(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk    (clk_i),
        .arst_n (arst_n_i),
        .clr    (state_reg != BUSY),
        .en     (state_reg == BUSY),
        .tc     (tc)
    );

    iob_reg #(.W(1)) u_timeout (
        .clk (clk_i), .arst_n (arst_n_i), .en (1'b1), .d (done_to), .q (timeout_o)
    );
`else
    assign tc        = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_wb_req_hold.sv
// Scoreboard bench for iob_wb_req_hold; watchdog scenarios follow IOB_WB_REQ_HOLD_TIMEOUT_EN.
module tb_iob_wb_req_hold;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [AW-1:0] s_adr = '0;
    logic [DW-1:0] s_dat = '0;
    logic [SW-1:0] s_sel = '0;
    logic          s_we = 1'b0;
    logic          s_cyc = 1'b0;
    logic          s_stb = 1'b0;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_o;
    logic          s_err_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic [SW-1:0] m_sel_o;
    logic          m_we_o;
    logic          m_cyc_o;
    logic          m_stb_o;
    logic [DW-1:0] m_dat = '0;
    logic          m_ack = 1'b0;
    logic          m_err = 1'b0;
    logic          clr = 1'b0;
    logic          timeout_o;
    logic          drop_o;

    typedef struct {
        logic          ack;
        logic          err;
        logic          to;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last_dat = '0;

    always #5 clk = ~clk;

    iob_wb_req_hold #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n),
        .s_adr_i   (s_adr),
        .s_dat_i   (s_dat),
        .s_sel_i   (s_sel),
        .s_we_i    (s_we),
        .s_cyc_i   (s_cyc),
        .s_stb_i   (s_stb),
        .s_dat_o   (s_dat_o),
        .s_ack_o   (s_ack_o),
        .s_err_o   (s_err_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_sel_o   (m_sel_o),
        .m_we_o    (m_we_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_dat_i   (m_dat),
        .m_ack_i   (m_ack),
        .m_err_i   (m_err),
        .clr_i     (clr),
        .timeout_o (timeout_o),
        .drop_o    (drop_o)
    );

    // Response monitor: every ack/err/timeout pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (s_ack_o || s_err_o || timeout_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got ack=%0b err=%0b to=%0b dat=%08h, required no response",
                         s_ack_o, s_err_o, timeout_o, s_dat_o);
            end else begin
                e = exp_q.pop_front();
                if ({s_ack_o, s_err_o, timeout_o, s_dat_o} !== {e.ack, e.err, e.to, e.dat}) begin
                    failures++;
                    $display("FAIL resp: got ack=%0b err=%0b to=%0b dat=%08h, required ack=%0b err=%0b to=%0b dat=%08h",
                             s_ack_o, s_err_o, timeout_o, s_dat_o, e.ack, e.err, e.to, e.dat);
                end else begin
                    $display("resp ok: ack=%0b err=%0b to=%0b dat=%08h", s_ack_o, s_err_o, timeout_o, s_dat_o);
                end
            end
        end
    end

    task automatic push(input logic ack, input logic err, input logic to, input logic [DW-1:0] dat);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.to  = to;
        e.dat = dat;
        exp_q.push_back(e);
        last_dat = dat;
    endtask

    // One-cycle upstream strobe; returns on the first negedge with the request captured.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic w);
        @(negedge clk);
        s_adr = a; s_dat = d; s_sel = s; s_we = w;
        s_cyc = 1'b1; s_stb = 1'b1;
        @(negedge clk);
        s_cyc = 1'b0; s_stb = 1'b0;
        $display("req adr=%08h dat=%08h sel=%0h we=%0b", a, d, s, w);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ack_o, s_err_o, timeout_o, drop_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, s_dat_o} !== '0) begin
            failures++;
            $display("FAIL reset_in: got cyc=%0b ack=%0b err=%0b drop=%0b adr=%08h, required all 0",
                     m_cyc_o, s_ack_o, s_err_o, drop_o, m_adr_o);
        end
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ack_o, s_err_o, timeout_o, drop_o, m_cyc_o, m_stb_o, m_adr_o, s_dat_o} !== '0) begin
            failures++;
            $display("FAIL reset_out: got cyc=%0b ack=%0b err=%0b drop=%0b, required all 0",
                     m_cyc_o, s_ack_o, s_err_o, drop_o);
        end
    endtask

    task automatic test_write();
        issue(32'h40, 32'hDEADBEEF, 4'hF, 1'b1);
        m_dat = 32'hA5A50001;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({m_cyc_o, m_stb_o, m_adr_o, m_dat_o, m_sel_o, m_we_o} !==
                {1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1}) begin
                failures++;
                $display("FAIL write_hold[%0d]: got cyc=%0b stb=%0b adr=%08h dat=%08h sel=%0h we=%0b, required 1 1 00000040 deadbeef f 1",
                         i, m_cyc_o, m_stb_o, m_adr_o, m_dat_o, m_sel_o, m_we_o);
            end
        end
        push(1'b1, 1'b0, 1'b0, m_dat);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if ({m_cyc_o, drop_o} !== 2'b00) begin
            failures++;
            $display("FAIL write_end: got cyc=%0b drop=%0b, required cyc=0 drop=0", m_cyc_o, drop_o);
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        issue(32'h44, 32'h0, 4'hF, 1'b0);
        checks++;
        if ({m_cyc_o, m_we_o, m_adr_o} !== {1'b1, 1'b0, 32'h44}) begin
            failures++;
            $display("FAIL read_req: got cyc=%0b we=%0b adr=%08h, required 1 0 00000044", m_cyc_o, m_we_o, m_adr_o);
        end
        m_dat = 32'h12345678;
        push(1'b1, 1'b0, 1'b0, 32'h12345678);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        m_dat = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (s_dat_o !== 32'h12345678) begin
            failures++;
            $display("FAIL read_hold: got s_dat=%08h, required 12345678", s_dat_o);
        end
    endtask

    task automatic test_ack_err();
        issue(32'h48, 32'h1, 4'h1, 1'b1);
        m_dat = 32'h0BADF00D;
        push(1'b0, 1'b1, 1'b0, 32'h0BADF00D);
        m_ack = 1'b1;
        m_err = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        issue(32'h80, 32'h11, 4'h1, 1'b1);
        s_adr = 32'h99; s_cyc = 1'b1; s_stb = 1'b1;
        @(negedge clk);
        checks++;
        if ({drop_o, m_adr_o, m_cyc_o} !== {1'b1, 32'h80, 1'b1}) begin
            failures++;
            $display("FAIL drop_set: got drop=%0b adr=%08h cyc=%0b, required 1 00000080 1", drop_o, m_adr_o, m_cyc_o);
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (drop_o !== 1'b1) begin
            failures++;
            $display("FAIL drop_clr_vs_set: got drop=%0b, required 1", drop_o);
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (drop_o !== 1'b0) begin
            failures++;
            $display("FAIL drop_clr: got drop=%0b, required 0", drop_o);
        end
        m_dat = 32'h0000C0DE;
        push(1'b1, 1'b0, 1'b0, 32'h0000C0DE);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(32'h100, 32'h5555, 4'h3, 1'b1);
        m_ack = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({m_cyc_o, m_stb_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_cyc: got cyc=%0b stb=%0b, required 0 0", m_cyc_o, m_stb_o);
        end
        repeat (2) @(negedge clk);
        m_ack = 1'b0;
        arst_n = 1'b1;
        last_dat = '0;
        @(negedge clk);
        checks++;
        if ({s_dat_o, m_cyc_o} !== {32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_idle: got s_dat=%08h cyc=%0b, required 00000000 0", s_dat_o, m_cyc_o);
        end
        issue(32'h104, 32'h0, 4'hF, 1'b0);
        m_dat = 32'hCAFE0001;
        push(1'b1, 1'b0, 1'b0, 32'hCAFE0001);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
    endtask

`ifdef IOB_WB_REQ_HOLD_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        hi = 0;
        issue(32'h200, 32'h2, 4'hF, 1'b1);
        push(1'b0, 1'b1, 1'b1, last_dat);
        for (int i = 0; i < 50 && m_cyc_o; i++) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != TO) begin
            failures++;
            $display("FAIL timeout_len: got cyc high %0d cycles, required %0d", hi, TO);
        end
        @(negedge clk);
    endtask

    task automatic test_ack_terminal();
        issue(32'h204, 32'h3, 4'hF, 1'b0);
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (m_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL terminal_cyc: got cyc=%0b, required 1", m_cyc_o);
        end
        m_dat = 32'h7E7E7E7E;
        push(1'b1, 1'b0, 1'b0, 32'h7E7E7E7E);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if (m_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL terminal_end: got cyc=%0b, required 0", m_cyc_o);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        int low;
        low = 0;
        issue(32'h300, 32'h4, 4'hF, 1'b0);
        repeat (1000) begin
            @(negedge clk);
            if (!m_cyc_o) low++;
        end
        checks++;
        if (low != 0) begin
            failures++;
            $display("FAIL no_timeout: got cyc low %0d cycles, required 0", low);
        end
        m_dat = 32'h600D600D;
        push(1'b1, 1'b0, 1'b0, 32'h600D600D);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ack_err();
        test_drop();
        test_reset_mid();
`ifdef IOB_WB_REQ_HOLD_TIMEOUT_EN
        test_timeout();
        test_ack_terminal();
`else
        test_no_timeout();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_resp: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
